sha2_k_sequencer: RTL and testbench

SHA2_K_SEQUENCER -- requirements
Module: sha2_k_sequencer

---
 rtl/sha2_k_sequencer_if.sv | 24 ++
 rtl/sha2_k_sequencer.sv | 133 +++++++++++++
 tb/tb_sha2_k_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_k_sequencer_if.sv
// Constant-stream bus between the SHA-2 round-constant sequencer and its consumer.
// The consumer drives start/k_ready; the sequencer drives the constant beat and status.
interface sha2_k_sequencer_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic              k_ready;
  logic              k_valid;
  logic [WORD_W-1:0] k;
  logic [6:0]        round;
  logic              k_last;
  logic              busy;
  logic              done;

  modport master (
    output start, k_ready,
    input  k_valid, k, round, k_last, busy, done
  );

  modport slave (
    input  start, k_ready,
    output k_valid, k, round, k_last, busy, done
  );
endinterface

// File: rtl/sha2_k_sequencer.sv
// Streams the FIPS 180-4 round constants K[0..ROUNDS-1] under a valid/ready handshake.
// SHA-256 constants are the top 32 bits of the SHA-512 ones, so one 64-bit table serves both widths.
module sha2_k_sequencer #(
  parameter int WORD_W = 32
) (
  input logic              clk,
  input logic              rst,
  sha2_k_sequencer_if.slave bus
);
  localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST   = 7'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_k_sequencer: WORD_W must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] k_p0, k_nxt;
  logic [6:0]        round_p0, round_nxt;
  logic              vld_p0, vld_nxt;
  logic              k_last_p0, k_last_nxt;
  logic              busy_p0, busy_nxt;
  logic              done_p0, done_nxt;
  logic [63:0]       k_full;
  logic              xfer;

  function automatic logic [63:0] k512(input logic [6:0] idx);
    logic [63:0] tbl [0:79];
    tbl = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };
    return (idx < 7'd80) ? tbl[idx] : 64'd0;
  endfunction

  assign xfer = vld_p0 && bus.k_ready;

  always_comb begin
    state_nxt = state;
    round_nxt = round_p0;
    vld_nxt   = vld_p0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          round_nxt = '0;
          vld_nxt   = 1'b1;
        end
      end
      RUN: begin
        // A restart outranks a simultaneous transfer, so no done pulse is emitted.
        if (bus.start) begin
          round_nxt = '0;
          vld_nxt   = 1'b1;
        end else if (xfer) begin
          if (round_p0 == LAST) begin
            state_nxt = DONE;
            vld_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            round_nxt = round_p0 + 7'd1;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          round_nxt = '0;
          vld_nxt   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
    busy_nxt   = (state_nxt == RUN);
    k_last_nxt = vld_nxt && (round_nxt == LAST);
    k_full     = k512(round_nxt);
    k_nxt      = vld_nxt ? WORD_W'(k_full >> (64 - WORD_W)) : k_p0;
  end

  // Output register stage: every bus output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_p0      <= '0;
      round_p0  <= '0;
      vld_p0    <= 1'b0;
      k_last_p0 <= 1'b0;
      busy_p0   <= 1'b0;
      done_p0   <= 1'b0;
    end else begin
      state     <= state_nxt;
      k_p0      <= k_nxt;
      round_p0  <= round_nxt;
      vld_p0    <= vld_nxt;
      k_last_p0 <= k_last_nxt;
      busy_p0   <= busy_nxt;
      done_p0   <= done_nxt;
    end
  end

  assign bus.k_valid = vld_p0;
  assign bus.k       = k_p0;
  assign bus.round   = round_p0;
  assign bus.k_last  = k_last_p0;
  assign bus.busy    = busy_p0;
  assign bus.done    = done_p0;
endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Bench for sha2_k_sequencer: derives the round constants from cube roots of primes and
// checks 32- and 64-bit instances under random back-pressure, restarts and resets.
module tb_sha2_k_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] kref32 [0:63];
  logic [63:0] kref64 [0:79];

  sha2_k_sequencer_if #(.WORD_W(32)) bus32 ();
  sha2_k_sequencer_if #(.WORD_W(64)) bus64 ();

  sha2_k_sequencer #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  sha2_k_sequencer #(.WORD_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // floor(frac(cbrt(p)) * 2^bits), found exactly by bisection on integer cubes
  function automatic logic [63:0] frac_cbrt(input int p, input int bits);
    logic [255:0] target, x, t;
    x      = '0;
    target = 256'(p) << (3 * bits);
    for (int b = bits + 3; b >= 0; b--) begin
      t = x | (256'd1 << b);
      if (t * t * t <= target) x = t;
    end
    return (bits == 64) ? x[63:0] : {32'd0, x[31:0]};
  endfunction

  task automatic build_model();
    int n;
    logic [63:0] v;
    n = 0;
    for (int c = 2; n < 80; c++) begin
      bit isp;
      isp = 1'b1;
      for (int d = 2; d * d <= c; d++) if (c % d == 0) isp = 1'b0;
      if (isp) begin
        kref64[n] = frac_cbrt(c, 64);
        if (n < 64) begin
          v         = frac_cbrt(c, 32);
          kref32[n] = v[31:0];
        end
        n++;
      end
    end
  endtask

  task automatic check_zero32(input string tag);
    check({tag, "_kv"}, 64'(bus32.k_valid), 64'd0);
    check({tag, "_k"}, 64'(bus32.k), 64'd0);
    check({tag, "_rnd"}, 64'(bus32.round), 64'd0);
    check({tag, "_last"}, 64'(bus32.k_last), 64'd0);
    check({tag, "_busy"}, 64'(bus32.busy), 64'd0);
    check({tag, "_done"}, 64'(bus32.done), 64'd0);
  endtask

  // One full 32-bit stream; optional random stall, restart at round rs, start in DONE.
  task automatic stream32(input bit rnd, input int rs, input bit chain, input bit skip_start);
    int   idx;
    int   guard;
    int   restart;
    bit   fin;
    logic rdy;
    restart = rs;
    if (!skip_start) begin
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
    end
    idx   = 0;
    guard = 0;
    fin   = 1'b0;
    while (!fin && guard < 3000) begin
      check("s32_kv", 64'(bus32.k_valid), 64'd1);
      check("s32_rnd", 64'(bus32.round), 64'(idx));
      check("s32_k", 64'(bus32.k), 64'(kref32[idx]));
      check("s32_last", 64'(bus32.k_last), 64'(idx == 63));
      check("s32_busy", 64'(bus32.busy), 64'd1);
      check("s32_done", 64'(bus32.done), 64'd0);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus32.k_ready = rdy;
      if (rdy && idx == restart) begin
        bus32.start = 1'b1;
        restart     = -1;
        tick();
        bus32.start = 1'b0;
        idx         = 0;
      end else begin
        tick();
        if (rdy) begin
          if (idx == 63) fin = 1'b1;
          else idx++;
        end
      end
      guard++;
    end
    check("s32_finished", 64'(fin), 64'd1);
    bus32.k_ready = 1'($urandom_range(0, 1));
    check("s32_end_kv", 64'(bus32.k_valid), 64'd0);
    check("s32_end_done", 64'(bus32.done), 64'd1);
    check("s32_end_busy", 64'(bus32.busy), 64'd0);
    check("s32_end_last", 64'(bus32.k_last), 64'd0);
    if (chain) begin
      bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0;
    end else begin
      tick();
      check("s32_post_done", 64'(bus32.done), 64'd0);
      check("s32_post_kv", 64'(bus32.k_valid), 64'd0);
      check("s32_post_busy", 64'(bus32.busy), 64'd0);
    end
  endtask

  task automatic stream64();
    logic [63:0] kv;
    bus64.start = 1'b1;
    tick();
    bus64.start   = 1'b0;
    bus64.k_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      kv = bus64.k;
      check("s64_kv", 64'(bus64.k_valid), 64'd1);
      check("s64_rnd", 64'(bus64.round), 64'(i));
      check("s64_k", kv, kref64[i]);
      check("s64_last", 64'(bus64.k_last), 64'(i == 79));
      if (i < 64) check("s64_hi32", {32'd0, kv[63:32]}, 64'(kref32[i]));
      tick();
    end
    check("s64_end_done", 64'(bus64.done), 64'd1);
    check("s64_end_kv", 64'(bus64.k_valid), 64'd0);
    tick();
    check("s64_post_done", 64'(bus64.done), 64'd0);
    bus64.k_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus32.start   = 1'b0;
    bus32.k_ready = 1'b0;
    bus64.start   = 1'b0;
    bus64.k_ready = 1'b0;
    build_model();
    #1 rst = 1'b1;
    #1;
    check_zero32("rst0");
    check("rst0_k64", bus64.k, 64'd0);
    check("rst0_kv64", 64'(bus64.k_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // start in the very first cycle after reset release, constant ready
    stream32(1'b0, -1, 1'b0, 1'b0);

    // k_ready while idle must not produce anything
    bus32.k_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_kv", 64'(bus32.k_valid), 64'd0);
      check("idle_done", 64'(bus32.done), 64'd0);
      check("idle_busy", 64'(bus32.busy), 64'd0);
    end

    stream32(1'b1, -1, 1'b0, 1'b0);
    stream32(1'b1, -1, 1'b0, 1'b0);
    stream32(1'b0, 17, 1'b0, 1'b0);
    stream32(1'b1, 17, 1'b0, 1'b0);

    // start during the DONE cycle chains straight into a new stream
    stream32(1'b0, -1, 1'b1, 1'b0);
    stream32(1'b1, -1, 1'b0, 1'b1);

    // asynchronous reset mid-stream at round 40
    bus32.start = 1'b1;
    tick();
    bus32.start   = 1'b0;
    bus32.k_ready = 1'b1;
    repeat (40) tick();
    check("pre_rst_rnd", 64'(bus32.round), 64'd40);
    #2 rst = 1'b1;
    #1;
    check_zero32("arst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_kv", 64'(bus32.k_valid), 64'd0);
      check("post_rst_rnd", 64'(bus32.round), 64'd0);
      check("post_rst_busy", 64'(bus32.busy), 64'd0);
    end
    stream32(1'b1, -1, 1'b0, 1'b0);

    stream64();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
